cache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate cache controller. It is the initiator that drives the cacheline store's load/edit/invalid interface.
- Sits between the CPU data port and the cacheline store on one side, and word-wide main memory on the other.
- Decides hit/miss, writes back dirty victims, refills lines word-by-word, and services CPU reads/writes and invalidates.

---
 rtl/cache_pkg.sv | 29 ++
 rtl/cache_if.sv | 49 ++++
 rtl/cache_ctrl.sv | 109 ++++++++++
 tb/tb_cache_ctrl.sv | 542 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared parameters, state encoding and address-field helpers for the direct-mapped data cache.
package cache_pkg;

  localparam int unsigned TAG_W          = 22;
  localparam int unsigned IDX_W          = 6;
  localparam int unsigned WORD_W         = 2;
  localparam int unsigned WORDS_PER_LINE = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWb   = 2'd1,
    StFill = 2'd2
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return addr[31:10];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
    return addr[9:4];
  endfunction

  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0]  tag,
                                            input logic [IDX_W-1:0]  idx,
                                            input logic [WORD_W-1:0] word);
    return {tag, idx, word, 2'b00};
  endfunction

endpackage

// File: rtl/cache_if.sv
// Bundles the CPU port, cacheline-store port and word-wide memory port of the cache controller.
interface cache_if;

  logic                      cpu_req;
  logic                      cpu_we;
  logic                      cpu_inv;
  logic [31:0]               cpu_addr;
  logic [31:0]               cpu_din;
  logic [31:0]               cpu_dout;
  logic                      cpu_ack;
  logic                      cpu_stall;

  logic [31:0]               c_addr;
  logic                      c_load;
  logic                      c_edit;
  logic                      c_invalid;
  logic [31:0]               c_din;
  logic                      c_hit;
  logic                      c_valid;
  logic                      c_dirty;
  logic [cache_pkg::TAG_W-1:0] c_tag;
  logic [31:0]               c_dout;

  logic                      mem_cs;
  logic                      mem_we;
  logic [31:0]               mem_addr;
  logic [31:0]               mem_wdata;
  logic [31:0]               mem_rdata;
  logic                      mem_ack;

  modport master (
    input  cpu_req, cpu_we, cpu_inv, cpu_addr, cpu_din,
    output cpu_dout, cpu_ack, cpu_stall,
    output c_addr, c_load, c_edit, c_invalid, c_din,
    input  c_hit, c_valid, c_dirty, c_tag, c_dout,
    output mem_cs, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    output cpu_req, cpu_we, cpu_inv, cpu_addr, cpu_din,
    input  cpu_dout, cpu_ack, cpu_stall,
    input  c_addr, c_load, c_edit, c_invalid, c_din,
    output c_hit, c_valid, c_dirty, c_tag, c_dout,
    input  mem_cs, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller: hit/miss decision, dirty victim
// write-back and word-by-word refill; a completed miss is acknowledged through the hit path.
module cache_ctrl
  import cache_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  cache_if.master  bus
);

  localparam logic [WORD_W-1:0] LastWord = WORD_W'(WORDS_PER_LINE - 1);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic              line_hit;

  assign line_hit = bus.c_valid & bus.c_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    bus.cpu_dout  = '0;
    bus.cpu_ack   = 1'b0;
    bus.cpu_stall = 1'b0;
    bus.c_addr    = '0;
    bus.c_load    = 1'b0;
    bus.c_edit    = 1'b0;
    bus.c_invalid = 1'b0;
    bus.c_din     = '0;
    bus.mem_cs    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    // The store must stay untouched while reset is held, so every output is gated by it.
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          bus.c_addr = bus.cpu_addr;
          if (bus.cpu_req && bus.cpu_inv) begin
            bus.c_invalid = 1'b1;
            bus.cpu_ack   = 1'b1;
          end else if (bus.cpu_req && line_hit) begin
            bus.cpu_ack = 1'b1;
            if (bus.cpu_we) begin
              bus.c_edit = 1'b1;
              bus.c_din  = bus.cpu_din;
            end else begin
              bus.cpu_dout = bus.c_dout;
            end
          end else if (bus.cpu_req) begin
            bus.cpu_stall = 1'b1;
            addr_d        = bus.cpu_addr;
            cnt_d         = '0;
            state_d       = (bus.c_valid && bus.c_dirty) ? StWb : StFill;
          end
        end

        StWb: begin
          bus.cpu_stall = 1'b1;
          bus.c_addr    = line_addr(addr_tag(addr_q), addr_idx(addr_q), cnt_q);
          bus.mem_cs    = 1'b1;
          bus.mem_we    = 1'b1;
          // Victim address is rebuilt from the stored tag, not the requesting tag.
          bus.mem_addr  = line_addr(bus.c_tag, addr_idx(addr_q), cnt_q);
          bus.mem_wdata = bus.c_dout;
          if (bus.mem_ack) begin
            cnt_d = cnt_q + WORD_W'(1);
            if (cnt_q == LastWord) begin
              state_d = StFill;
            end
          end
        end

        StFill: begin
          bus.cpu_stall = 1'b1;
          bus.mem_cs    = 1'b1;
          bus.mem_addr  = line_addr(addr_tag(addr_q), addr_idx(addr_q), cnt_q);
          bus.c_addr    = bus.mem_addr;
          if (bus.mem_ack) begin
            bus.c_load = 1'b1;
            bus.c_din  = bus.mem_rdata;
            cnt_d      = cnt_q + WORD_W'(1);
            if (cnt_q == LastWord) begin
              state_d = StIdle;
            end
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: behavioural cacheline store and memory, directed scenarios
// plus randomized traffic checked against a line-level cache model.
module tb_cache_ctrl;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_if bus ();

  cache_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural cacheline store.
  logic             st_valid [64];
  logic             st_dirty [64];
  logic [TAG_W-1:0] st_tag   [64];
  logic [31:0]      st_data  [64][4];

  always_comb begin
    bus.c_valid = st_valid[bus.c_addr[9:4]];
    bus.c_dirty = st_dirty[bus.c_addr[9:4]];
    bus.c_tag   = st_tag[bus.c_addr[9:4]];
    bus.c_hit   = (st_tag[bus.c_addr[9:4]] == bus.c_addr[31:10]);
    bus.c_dout  = st_data[bus.c_addr[9:4]][bus.c_addr[3:2]];
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        st_valid[i] <= 1'b0;
        st_dirty[i] <= 1'b0;
      end
    end else if (bus.c_load) begin
      st_data[bus.c_addr[9:4]][bus.c_addr[3:2]] <= bus.c_din;
      st_tag[bus.c_addr[9:4]]   <= bus.c_addr[31:10];
      st_valid[bus.c_addr[9:4]] <= 1'b1;
      st_dirty[bus.c_addr[9:4]] <= 1'b0;
    end else if (bus.c_edit) begin
      st_data[bus.c_addr[9:4]][bus.c_addr[3:2]] <= bus.c_din;
      st_dirty[bus.c_addr[9:4]] <= 1'b1;
    end else if (bus.c_invalid) begin
      st_valid[bus.c_addr[9:4]] <= 1'b0;
    end
  end

  function automatic logic [31:0] init_word(input int unsigned i);
    return (i < 4) ? 32'h1111_1111 : (32'hC0DE_0000 | i);
  endfunction

  // Word-wide memory with programmable ack latency.
  logic [31:0] mem_q [4096];
  bit          mem_init_q = 1'b0;
  int unsigned lat = 2;
  int unsigned wait_q = 0;
  logic        mem_ack_q = 1'b0;
  logic        spur_ack = 1'b0;

  assign bus.mem_ack = mem_ack_q | spur_ack;

  always @(posedge clk) begin
    mem_ack_q <= 1'b0;
    if (!mem_init_q) begin
      for (int i = 0; i < 4096; i++) mem_q[i] <= init_word(i);
      mem_init_q <= 1'b1;
    end
    if (rst) begin
      wait_q <= 0;
    end else if (bus.mem_cs && !mem_ack_q) begin
      if (wait_q + 1 >= lat) begin
        mem_ack_q     <= 1'b1;
        wait_q        <= 0;
        bus.mem_rdata <= mem_q[bus.mem_addr[13:2]];
        if (bus.mem_we) mem_q[bus.mem_addr[13:2]] <= bus.mem_wdata;
      end else begin
        wait_q <= wait_q + 1;
      end
    end else begin
      wait_q <= 0;
    end
  end

  // Monotonic activity monitor; tasks work on deltas from snapshots.
  int unsigned n_load = 0, n_edit = 0, n_inv = 0, n_stall = 0, n_cs = 0, n_ack = 0;
  int unsigned onehot_bad = 0;
  int unsigned last_ack_cyc = 0;
  logic [31:0] edit_din = '0;
  logic [31:0] wb_addr_q[$], wb_data_q[$], fill_addr_q[$];

  always @(negedge clk) begin
    if (bus.c_load) n_load <= n_load + 1;
    if (bus.c_edit) begin
      n_edit   <= n_edit + 1;
      edit_din <= bus.c_din;
    end
    if (bus.c_invalid) n_inv <= n_inv + 1;
    if (bus.cpu_stall) n_stall <= n_stall + 1;
    if (bus.mem_cs) n_cs <= n_cs + 1;
    if (bus.cpu_ack) n_ack <= n_ack + 1;
    if ($countones({bus.c_load, bus.c_edit, bus.c_invalid}) > 1) onehot_bad <= onehot_bad + 1;
    if (bus.mem_cs && bus.mem_ack) begin
      last_ack_cyc <= cyc;
      if (bus.mem_we) begin
        wb_addr_q.push_back(bus.mem_addr);
        wb_data_q.push_back(bus.mem_wdata);
      end else begin
        fill_addr_q.push_back(bus.mem_addr);
      end
    end
  end

  task automatic cpu_access(input logic we, input logic inv, input logic [31:0] addr,
                            input logic [31:0] din, output logic [31:0] dout,
                            output logic acked, output int lat_cyc, output int ack_cyc);
    int start;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = we;
    bus.cpu_inv  = inv;
    bus.cpu_addr = addr;
    bus.cpu_din  = din;
    start   = int'(cyc);
    acked   = 1'b0;
    dout    = '0;
    lat_cyc = -1;
    ack_cyc = -1;
    for (int i = 0; i < 300 && !acked; i++) begin
      @(negedge clk);
      if (bus.cpu_ack) begin
        acked   = 1'b1;
        dout    = bus.cpu_dout;
        ack_cyc = int'(cyc);
        lat_cyc = ack_cyc - start;
      end
    end
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    bus.cpu_inv = 1'b0;
  endtask

  task automatic test_reset();
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b1;
    bus.cpu_inv  = 1'b0;
    bus.cpu_addr = 32'h0000_0404;
    bus.cpu_din  = 32'hDEAD_BEEF;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.cpu_ack, bus.cpu_stall, bus.c_load, bus.c_edit, bus.c_invalid, bus.mem_cs,
         bus.mem_we} !== 7'b0) begin
      bad++;
      $display("FAIL reset_strobes: got %b want 0000000", {bus.cpu_ack, bus.cpu_stall,
               bus.c_load, bus.c_edit, bus.c_invalid, bus.mem_cs, bus.mem_we});
    end
    total++;
    if ({bus.c_addr, bus.c_din, bus.mem_addr, bus.mem_wdata, bus.cpu_dout} !== '0) begin
      bad++;
      $display("FAIL reset_buses: c_addr=%h c_din=%h mem_addr=%h want all zero",
               bus.c_addr, bus.c_din, bus.mem_addr);
    end
    bus.cpu_req  = 1'b0;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_din  = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.cpu_ack, bus.cpu_stall, bus.mem_cs, bus.c_load} !== 4'b0) begin
      bad++;
      $display("FAIL reset_idle: got %b want 0000",
               {bus.cpu_ack, bus.cpu_stall, bus.mem_cs, bus.c_load});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_fill();
    logic [31:0] dout;
    logic        acked;
    int          l, ac;
    int unsigned fb = fill_addr_q.size(), wb = wb_addr_q.size(), lb = n_load, sb = n_stall;
    lat = 2;
    cpu_access(1'b0, 1'b0, 32'h0000_0004, '0, dout, acked, l, ac);
    total++;
    if (fill_addr_q.size() - fb != 4 || wb_addr_q.size() != wb) begin
      bad++;
      $display("FAIL fill_beats: fill=%0d wb=%0d want 4/0", fill_addr_q.size() - fb,
               wb_addr_q.size() - wb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (fill_addr_q[fb + i] !== 32'(i * 4)) begin
          bad++;
          $display("FAIL fill_addr[%0d]: got %h want %h", i, fill_addr_q[fb + i], i * 4);
        end
      end
    end
    total++;
    if (n_load - lb != 4) begin
      bad++;
      $display("FAIL fill_loads: got %0d want 4", n_load - lb);
    end
    total++;
    if (!acked || dout !== 32'h1111_1111) begin
      bad++;
      $display("FAIL fill_dout: ack=%b got %h want 11111111", acked, dout);
    end
    total++;
    if (ac != int'(last_ack_cyc) + 1) begin
      bad++;
      $display("FAIL fill_ack_cycle: got %0d want %0d", ac, last_ack_cyc + 1);
    end
    total++;
    if (n_stall - sb < 5) begin
      bad++;
      $display("FAIL fill_stall: got %0d cycles want >=5", n_stall - sb);
    end
  endtask

  task automatic test_hit_read();
    logic [31:0] dout;
    logic        acked;
    int          l, ac;
    int unsigned cb = n_cs, sb = n_stall;
    cpu_access(1'b0, 1'b0, 32'h0000_0008, '0, dout, acked, l, ac);
    total++;
    if (!acked || l != 0 || dout !== 32'h1111_1111) begin
      bad++;
      $display("FAIL hit_read: ack=%b lat=%0d dout=%h want 1/0/11111111", acked, l, dout);
    end
    total++;
    if (n_cs != cb || n_stall != sb) begin
      bad++;
      $display("FAIL hit_quiet: mem_cs=%0d stall=%0d want 0/0", n_cs - cb, n_stall - sb);
    end
  endtask

  task automatic test_write_hit();
    logic [31:0] dout;
    logic        acked;
    int          l, ac;
    int unsigned eb = n_edit;
    cpu_access(1'b1, 1'b0, 32'h0000_0008, 32'h2222_2222, dout, acked, l, ac);
    total++;
    if (!acked || l != 0 || n_edit - eb != 1 || edit_din !== 32'h2222_2222) begin
      bad++;
      $display("FAIL write_hit: ack=%b lat=%0d edits=%0d c_din=%h want 1/0/1/22222222",
               acked, l, n_edit - eb, edit_din);
    end
    total++;
    if (st_dirty[0] !== 1'b1) begin
      bad++;
      $display("FAIL write_dirty: got %b want 1", st_dirty[0]);
    end
  endtask

  task automatic test_dirty_evict();
    logic [31:0] dout;
    logic        acked;
    int          l, ac;
    logic [31:0] exp_wb [4];
    int unsigned wb = wb_addr_q.size(), fb = fill_addr_q.size();
    exp_wb = '{32'h1111_1111, 32'h1111_1111, 32'h2222_2222, 32'h1111_1111};
    cpu_access(1'b0, 1'b0, 32'h0000_0408, '0, dout, acked, l, ac);
    total++;
    if (wb_addr_q.size() - wb != 4 || fill_addr_q.size() - fb != 4) begin
      bad++;
      $display("FAIL evict_beats: wb=%0d fill=%0d want 4/4", wb_addr_q.size() - wb,
               fill_addr_q.size() - fb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wb_addr_q[wb + i] !== 32'(i * 4) || wb_data_q[wb + i] !== exp_wb[i] ||
            fill_addr_q[fb + i] !== 32'(32'h400 + i * 4)) begin
          bad++;
          $display("FAIL evict_beat[%0d]: wb %h=%h fill %h want %h=%h fill %h", i,
                   wb_addr_q[wb + i], wb_data_q[wb + i], fill_addr_q[fb + i], i * 4,
                   exp_wb[i], 32'h400 + i * 4);
        end
      end
    end
    total++;
    if (!acked || dout !== 32'hC0DE_0102 || ac != int'(last_ack_cyc) + 1) begin
      bad++;
      $display("FAIL evict_dout: ack=%b dout=%h want C0DE0102", acked, dout);
    end
  endtask

  task automatic test_inv();
    logic [31:0] dout;
    logic        acked;
    int          l, ac;
    int unsigned ib = n_inv, cb = n_cs, wb = wb_addr_q.size(), fb = fill_addr_q.size();
    cpu_access(1'b0, 1'b1, 32'h0000_0400, '0, dout, acked, l, ac);
    total++;
    if (!acked || l != 0 || n_inv - ib != 1 || n_cs != cb) begin
      bad++;
      $display("FAIL inv: ack=%b lat=%0d inv=%0d cs=%0d want 1/0/1/0", acked, l,
               n_inv - ib, n_cs - cb);
    end
    cpu_access(1'b0, 1'b0, 32'h0000_0400, '0, dout, acked, l, ac);
    total++;
    if (wb_addr_q.size() != wb || fill_addr_q.size() - fb != 4 || dout !== 32'hC0DE_0100) begin
      bad++;
      $display("FAIL inv_refill: wb=%0d fill=%0d dout=%h want 0/4/C0DE0100",
               wb_addr_q.size() - wb, fill_addr_q.size() - fb, dout);
    end
  endtask

  task automatic test_spurious_ack();
    logic [31:0] dout;
    logic        acked;
    int          l, ac;
    int unsigned cb = n_cs, lb = n_load;
    spur_ack = 1'b1;
    @(posedge clk);
    #1;
    spur_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cpu_access(1'b0, 1'b0, 32'h0000_0400, '0, dout, acked, l, ac);
    total++;
    if (n_cs != cb || n_load != lb || l != 0 || dout !== 32'hC0DE_0100) begin
      bad++;
      $display("FAIL spurious_ack: cs=%0d loads=%0d lat=%0d dout=%h want 0/0/0/C0DE0100",
               n_cs - cb, n_load - lb, l, dout);
    end
  endtask

  task automatic test_drop_req();
    logic [31:0] dout;
    logic        acked;
    int          l, ac;
    bit          seen = 1'b0;
    int unsigned lb = n_load, kb = n_ack;
    lat = 2;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h0000_0800;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = bus.c_load;
    end
    bus.cpu_req = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    total++;
    if (n_load - lb != 4 || n_ack != kb) begin
      bad++;
      $display("FAIL drop_req: loads=%0d acks=%0d want 4/0", n_load - lb, n_ack - kb);
    end
    cpu_access(1'b0, 1'b0, 32'h0000_0800, '0, dout, acked, l, ac);
    total++;
    if (l != 0 || dout !== 32'hC0DE_0200) begin
      bad++;
      $display("FAIL drop_rehit: lat=%0d dout=%h want 0/C0DE0200", l, dout);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] dout;
    logic        acked;
    int          l, ac;
    bit          seen = 1'b0;
    int unsigned lb, wb, fb;
    lat = 2;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h0000_1000;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = bus.c_load;
    end
    @(negedge clk);
    rst         = 1'b1;
    bus.cpu_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    lb  = n_load;
    @(negedge clk);
    total++;
    if ({bus.c_load, bus.c_edit, bus.c_invalid, bus.mem_cs, bus.cpu_stall, bus.cpu_ack}
        !== 6'b0) begin
      bad++;
      $display("FAIL mid_reset_strobes: got %b want 000000", {bus.c_load, bus.c_edit,
               bus.c_invalid, bus.mem_cs, bus.cpu_stall, bus.cpu_ack});
    end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (n_load != lb) begin
      bad++;
      $display("FAIL mid_reset_quiet: loads=%0d want 0", n_load - lb);
    end
    wb = wb_addr_q.size();
    fb = fill_addr_q.size();
    cpu_access(1'b0, 1'b0, 32'h0000_1000, '0, dout, acked, l, ac);
    total++;
    if (wb_addr_q.size() != wb || fill_addr_q.size() - fb != 4 || dout !== 32'hC0DE_0400) begin
      bad++;
      $display("FAIL mid_reset_refill: wb=%0d fill=%0d dout=%h want 0/4/C0DE0400",
               wb_addr_q.size() - wb, fill_addr_q.size() - fb, dout);
    end
  endtask

  // Line-level reference cache over a flat backing memory.
  logic             r_valid [64];
  logic             r_dirty [64];
  int unsigned      r_tag   [64];
  logic [31:0]      r_data  [64][4];
  logic [31:0]      r_mem   [4096];

  task automatic test_random();
    logic [31:0] dout, exp_dout, addr, din;
    logic        acked, we, inv, exp_hit;
    int          l, ac;
    int unsigned op, idx, tg, w, exp_wb, exp_fill, diffs;
    int unsigned wb, fb, eb, ib;
    for (int i = 0; i < 64; i++) begin
      r_valid[i] = 1'b0;
      r_dirty[i] = 1'b0;
    end
    for (int i = 0; i < 4096; i++) r_mem[i] = init_word(i);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 150; n++) begin
      op   = $urandom_range(0, 99);
      we   = (op < 35);
      inv  = (op >= 85);
      tg   = $urandom_range(8, 11);
      idx  = $urandom_range(0, 3);
      w    = $urandom_range(0, 3);
      addr = 32'(tg * 1024 + idx * 16 + w * 4);
      din  = $urandom;
      lat  = $urandom_range(1, 3);
      exp_wb   = 0;
      exp_fill = 0;
      exp_hit  = 1'b1;
      exp_dout = '0;
      if (inv) begin
        r_valid[idx] = 1'b0;
      end else begin
        if (!(r_valid[idx] && r_tag[idx] == tg)) begin
          exp_hit = 1'b0;
          if (r_valid[idx] && r_dirty[idx]) begin
            exp_wb = 4;
            for (int k = 0; k < 4; k++) r_mem[r_tag[idx] * 256 + idx * 4 + k] = r_data[idx][k];
          end
          exp_fill = 4;
          for (int k = 0; k < 4; k++) r_data[idx][k] = r_mem[tg * 256 + idx * 4 + k];
          r_valid[idx] = 1'b1;
          r_dirty[idx] = 1'b0;
          r_tag[idx]   = tg;
        end
        if (we) begin
          r_data[idx][w] = din;
          r_dirty[idx]   = 1'b1;
        end else begin
          exp_dout = r_data[idx][w];
        end
      end
      wb = wb_addr_q.size();
      fb = fill_addr_q.size();
      eb = n_edit;
      ib = n_inv;
      cpu_access(we, inv, addr, din, dout, acked, l, ac);
      total++;
      if (!acked || wb_addr_q.size() - wb != exp_wb || fill_addr_q.size() - fb != exp_fill) begin
        bad++;
        $display("FAIL rnd_flow[%0d] addr=%h: ack=%b wb=%0d fill=%0d want 1/%0d/%0d", n, addr,
                 acked, wb_addr_q.size() - wb, fill_addr_q.size() - fb, exp_wb, exp_fill);
      end
      total++;
      if ((!we && !inv && dout !== exp_dout) || n_edit - eb != 32'(we && !inv) ||
          n_inv - ib != 32'(inv)) begin
        bad++;
        $display("FAIL rnd_data[%0d] addr=%h: dout=%h want %h edits=%0d invs=%0d", n, addr,
                 dout, exp_dout, n_edit - eb, n_inv - ib);
      end
      total++;
      if ((exp_hit && l != 0) || (!exp_hit && ac != int'(last_ack_cyc) + 1)) begin
        bad++;
        $display("FAIL rnd_latency[%0d]: lat=%0d ack_cyc=%0d last_mem_ack=%0d hit=%b", n, l,
                 ac, last_ack_cyc, exp_hit);
      end
    end
    diffs = 0;
    for (int i = 2048; i < 3072; i++) if (mem_q[i] !== r_mem[i]) diffs++;
    total++;
    if (diffs != 0) begin
      bad++;
      $display("FAIL rnd_memory: got %0d differing words want 0", diffs);
    end
    total++;
    if (onehot_bad != 0) begin
      bad++;
      $display("FAIL store_onehot: got %0d overlapping cycles want 0", onehot_bad);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_req  = 1'b0;
    bus.cpu_we   = 1'b0;
    bus.cpu_inv  = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_din  = '0;
    test_reset();
    test_first_fill();
    test_hit_read();
    test_write_hit();
    test_dirty_evict();
    test_inv();
    test_spurious_ack();
    test_drop_req();
    test_reset_mid_fill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
